// File: rtl/if_id_pipe_ctrl_if.sv
// IF/ID control bundle: fetch-side inputs, hazard/flush requests and the
// registered IF/ID fields plus stall/flush statistics.
interface if_id_pipe_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int CNT_W = 16
);
  logic             stall_in;
  logic             branch_taken;
  logic [XLEN-1:0]  if_pc;
  logic [ILEN-1:0]  if_instr;
  logic             pc_write;
  logic [XLEN-1:0]  if_id_pc;
  logic [ILEN-1:0]  if_id_instr;
  logic             if_id_valid;
  logic             id_ex_bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             stall_err;

  modport master (
    output stall_in, branch_taken, if_pc, if_instr,
    input  pc_write, if_id_pc, if_id_instr, if_id_valid, id_ex_bubble,
           stall_cnt, flush_cnt, stall_err
  );

  modport slave (
    input  stall_in, branch_taken, if_pc, if_instr,
    output pc_write, if_id_pc, if_id_instr, if_id_valid, id_ex_bubble,
           stall_cnt, flush_cnt, stall_err
  );
endinterface

// File: rtl/if_id_pipe_ctrl.sv
// IF/ID pipeline register with load-use stall / branch flush application,
// PC write gating, saturating statistics and a runaway-stall watchdog.
module if_id_pipe_ctrl #(
  parameter int              XLEN      = 32,
  parameter int              ILEN      = 32,
  parameter logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013,
  parameter int              CNT_W     = 16,
  parameter int              MAX_STALL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  if_id_pipe_ctrl_if.slave bus
);

  localparam int                RUN_W   = $clog2(MAX_STALL + 2);
  localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(MAX_STALL + 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            valid;
  } ifid_t;

  localparam ifid_t IFID_RST = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};

  state_e           state_q, state_nxt;
  ifid_t            ifid_q, ifid_nxt;
  logic [RUN_W-1:0] run_q, run_nxt;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_nxt;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_nxt;
  logic             err_q, err_nxt;
  logic             do_flush, do_stall;

  // Flush outranks stall: a stall request on a flushing cycle is dropped.
  assign do_flush = bus.branch_taken;
  assign do_stall = bus.stall_in & ~bus.branch_taken;

  assign bus.pc_write     = ~bus.stall_in | bus.branch_taken;
  assign bus.id_ex_bubble =  bus.stall_in | bus.branch_taken;

  // State records which action the most recent edge applied.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_RUN, S_FLUSH, S_STALL: begin
        if (do_flush)      state_nxt = S_FLUSH;
        else if (do_stall) state_nxt = S_STALL;
        else               state_nxt = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    ifid_nxt = ifid_q;
    if (do_flush) begin
      ifid_nxt = IFID_RST;
    end else if (!do_stall) begin
      ifid_nxt.pc    = bus.if_pc;
      ifid_nxt.instr = bus.if_instr;
      ifid_nxt.valid = 1'b1;
    end
  end

  // Run length of back-to-back stall edges; any other edge restarts it.
  always_comb begin
    run_nxt = '0;
    if (state_nxt == S_STALL)
      run_nxt = (run_q == RUN_MAX) ? RUN_MAX : run_q + RUN_W'(1);
    err_nxt = err_q | (run_nxt == RUN_MAX);
  end

  always_comb begin
    stall_cnt_nxt = stall_cnt_q;
    flush_cnt_nxt = flush_cnt_q;
    if (do_stall && stall_cnt_q != '1) stall_cnt_nxt = stall_cnt_q + CNT_W'(1);
    if (do_flush && flush_cnt_q != '1) flush_cnt_nxt = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      ifid_q      <= IFID_RST;
      run_q       <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_nxt;
      ifid_q      <= ifid_nxt;
      run_q       <= run_nxt;
      err_q       <= err_nxt;
      stall_cnt_q <= stall_cnt_nxt;
      flush_cnt_q <= flush_cnt_nxt;
    end
  end

  assign bus.if_id_pc    = ifid_q.pc;
  assign bus.if_id_instr = ifid_q.instr;
  assign bus.if_id_valid = ifid_q.valid;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;
  assign bus.stall_err   = err_q;

endmodule

// File: tb/tb_if_id_pipe_ctrl.sv
// Randomized and directed checks of if_id_pipe_ctrl against a transaction-level
// model; a second CNT_W=4 instance shares stimulus to exercise saturation.
module tb_if_id_pipe_ctrl;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int MAXS = 4;

  logic clk, rst_n;
  logic stall_in, branch_taken;
  logic [31:0] if_pc, if_instr;

  if_id_pipe_ctrl_if #(.XLEN(32), .ILEN(32), .CNT_W(16)) ifa ();
  if_id_pipe_ctrl_if #(.XLEN(32), .ILEN(32), .CNT_W(4))  ifb ();

  assign ifa.stall_in = stall_in;  assign ifa.branch_taken = branch_taken;
  assign ifa.if_pc    = if_pc;     assign ifa.if_instr     = if_instr;
  assign ifb.stall_in = stall_in;  assign ifb.branch_taken = branch_taken;
  assign ifb.if_pc    = if_pc;     assign ifb.if_instr     = if_instr;

  if_id_pipe_ctrl #(.CNT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(ifa));
  if_id_pipe_ctrl #(.CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Reference model: unbounded event counts, saturation applied when comparing.
  logic [31:0] m_pc, m_instr;
  logic        m_valid, m_err;
  int          m_sc, m_fc, m_run;

  function automatic int sat(int v, int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_instr = NOP; m_valid = 0; m_err = 0;
    m_sc = 0; m_fc = 0; m_run = 0;
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] pc, input logic [31:0] ins);
    stall_in = s; branch_taken = b; if_pc = pc; if_instr = ins;
    #1;
  endtask

  task automatic edge_step();
    @(posedge clk);
    if (branch_taken) begin
      m_pc = 0; m_instr = NOP; m_valid = 0; m_fc++; m_run = 0;
    end else if (stall_in) begin
      m_sc++;
      if (m_run < MAXS + 1) m_run++;
      if (m_run == MAXS + 1) m_err = 1;
    end else begin
      m_pc = if_pc; m_instr = if_instr; m_valid = 1; m_run = 0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0;
    drive(0, 0, 32'h0, 32'h0);
    model_reset();
    checks++; if (ifa.if_id_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", ifa.if_id_pc); end
    checks++; if (ifa.if_id_instr !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", ifa.if_id_instr, NOP); end
    checks++; if (ifa.if_id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ifa.if_id_valid); end
    checks++; if (ifa.stall_cnt !== 16'd0 || ifa.flush_cnt !== 16'd0 || ifa.stall_err !== 1'b0) begin
      failures++; $display("FAIL reset_stats sc=%0d fc=%0d err=%b exp=0/0/0", ifa.stall_cnt, ifa.flush_cnt, ifa.stall_err); end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_fetch();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 32'(i * 4), 32'h1000_0000 + 32'(i));
      checks++; if (ifa.pc_write !== 1'b1 || ifa.id_ex_bubble !== 1'b0) begin
        failures++; $display("FAIL fetch_comb pw=%b bub=%b exp=1/0", ifa.pc_write, ifa.id_ex_bubble); end
      edge_step();
      checks++; if (ifa.if_id_pc !== 32'(i * 4) || ifa.if_id_instr !== 32'h1000_0000 + 32'(i) || ifa.if_id_valid !== 1'b1) begin
        failures++; $display("FAIL fetch_reg pc=%h ins=%h v=%b exp pc=%h", ifa.if_id_pc, ifa.if_id_instr, ifa.if_id_valid, i * 4); end
    end
    checks++; if (ifa.stall_cnt !== 16'd0 || ifa.flush_cnt !== 16'd0) begin
      failures++; $display("FAIL fetch_cnts sc=%0d fc=%0d exp=0/0", ifa.stall_cnt, ifa.flush_cnt); end
  endtask

  task automatic test_stall();
    drive(1, 0, 32'hC, 32'hDEAD_BEEF);
    checks++; if (ifa.pc_write !== 1'b0 || ifa.id_ex_bubble !== 1'b1) begin
      failures++; $display("FAIL stall_comb pw=%b bub=%b exp=0/1", ifa.pc_write, ifa.id_ex_bubble); end
    edge_step();
    checks++; if (ifa.if_id_pc !== 32'h8 || ifa.if_id_valid !== 1'b1) begin
      failures++; $display("FAIL stall_hold pc=%h v=%b exp=8/1", ifa.if_id_pc, ifa.if_id_valid); end
    checks++; if (ifa.stall_cnt !== 16'd1) begin failures++; $display("FAIL stall_cnt got=%0d exp=1", ifa.stall_cnt); end
    drive(0, 0, 32'hC, 32'h00A0_0093);
    edge_step();
    checks++; if (ifa.if_id_pc !== 32'hC || ifa.if_id_instr !== 32'h00A0_0093) begin
      failures++; $display("FAIL stall_resume pc=%h ins=%h exp=c/00a00093", ifa.if_id_pc, ifa.if_id_instr); end
  endtask

  task automatic test_flush();
    drive(0, 1, 32'h10, 32'h1111_1111);
    checks++; if (ifa.pc_write !== 1'b1 || ifa.id_ex_bubble !== 1'b1) begin
      failures++; $display("FAIL flush_comb pw=%b bub=%b exp=1/1", ifa.pc_write, ifa.id_ex_bubble); end
    edge_step();
    checks++; if (ifa.if_id_instr !== NOP || ifa.if_id_valid !== 1'b0 || ifa.if_id_pc !== 32'h0) begin
      failures++; $display("FAIL flush_reg ins=%h v=%b pc=%h exp=%h/0/0", ifa.if_id_instr, ifa.if_id_valid, ifa.if_id_pc, NOP); end
    checks++; if (ifa.flush_cnt !== 16'd1) begin failures++; $display("FAIL flush_cnt got=%0d exp=1", ifa.flush_cnt); end
    drive(0, 0, 32'h40, 32'h2222_2222);
    edge_step();
    checks++; if (ifa.if_id_pc !== 32'h40 || ifa.if_id_valid !== 1'b1) begin
      failures++; $display("FAIL flush_reload pc=%h v=%b exp=40/1", ifa.if_id_pc, ifa.if_id_valid); end
  endtask

  task automatic test_both();
    int sc0, fc0;
    sc0 = m_sc; fc0 = m_fc;
    drive(1, 1, 32'h44, 32'h3333_3333);
    checks++; if (ifa.pc_write !== 1'b1 || ifa.id_ex_bubble !== 1'b1) begin
      failures++; $display("FAIL both_comb pw=%b bub=%b exp=1/1", ifa.pc_write, ifa.id_ex_bubble); end
    edge_step();
    checks++; if (ifa.if_id_valid !== 1'b0 || ifa.if_id_instr !== NOP) begin
      failures++; $display("FAIL both_flush v=%b ins=%h exp=0/%h", ifa.if_id_valid, ifa.if_id_instr, NOP); end
    checks++; if (ifa.flush_cnt !== 16'(fc0 + 1) || ifa.stall_cnt !== 16'(sc0)) begin
      failures++; $display("FAIL both_cnts fc=%0d sc=%0d exp=%0d/%0d", ifa.flush_cnt, ifa.stall_cnt, fc0 + 1, sc0); end
  endtask

  task automatic test_watchdog();
    drive(0, 0, 32'h50, 32'h5);
    edge_step();
    for (int i = 1; i <= 5; i++) begin
      drive(1, 0, 32'h54, 32'h6);
      edge_step();
      checks++; if (ifa.stall_err !== (i == 5)) begin
        failures++; $display("FAIL wd_err_%0d got=%b exp=%b", i, ifa.stall_err, i == 5); end
    end
    checks++; if (ifa.stall_cnt !== 16'(m_sc)) begin failures++; $display("FAIL wd_cnt got=%0d exp=%0d", ifa.stall_cnt, m_sc); end
    drive(0, 0, 32'h58, 32'h7);
    edge_step();
    checks++; if (ifa.stall_err !== 1'b1 || ifa.if_id_pc !== 32'h58) begin
      failures++; $display("FAIL wd_sticky err=%b pc=%h exp=1/58", ifa.stall_err, ifa.if_id_pc); end
  endtask

  task automatic test_random();
    logic s, b;
    for (int i = 0; i < 300; i++) begin
      s = ($urandom_range(0, 9) < 4);
      b = ($urandom_range(0, 9) < 2);
      drive(s, b, $urandom, $urandom);
      checks++; if (ifa.pc_write !== !(s && !b) || ifa.id_ex_bubble !== (s || b)) begin
        failures++; $display("FAIL rnd_comb[%0d] pw=%b bub=%b s=%b b=%b", i, ifa.pc_write, ifa.id_ex_bubble, s, b); end
      edge_step();
      checks++; if (ifa.if_id_pc !== m_pc || ifa.if_id_instr !== m_instr || ifa.if_id_valid !== m_valid) begin
        failures++; $display("FAIL rnd_reg[%0d] pc=%h/%h ins=%h/%h v=%b/%b", i, ifa.if_id_pc, m_pc, ifa.if_id_instr, m_instr, ifa.if_id_valid, m_valid); end
      checks++; if (ifa.stall_cnt !== 16'(sat(m_sc, 16)) || ifa.flush_cnt !== 16'(sat(m_fc, 16)) || ifa.stall_err !== m_err) begin
        failures++; $display("FAIL rnd_stat[%0d] sc=%0d/%0d fc=%0d/%0d err=%b/%b", i, ifa.stall_cnt, m_sc, ifa.flush_cnt, m_fc, ifa.stall_err, m_err); end
      checks++; if (ifb.stall_cnt !== 4'(sat(m_sc, 4)) || ifb.flush_cnt !== 4'(sat(m_fc, 4))) begin
        failures++; $display("FAIL rnd_sat4[%0d] sc=%0d/%0d fc=%0d/%0d", i, ifb.stall_cnt, sat(m_sc, 4), ifb.flush_cnt, sat(m_fc, 4)); end
    end
  endtask

  task automatic test_saturate_reset();
    rst_n = 0; #1; model_reset();
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 32'h60, 32'h8);
      edge_step();
    end
    checks++; if (ifb.stall_cnt !== 4'hF || ifa.stall_cnt !== 16'd20) begin
      failures++; $display("FAIL sat_stall sc4=%h sc16=%0d exp=f/20", ifb.stall_cnt, ifa.stall_cnt); end
    checks++; if (ifb.stall_err !== 1'b1) begin failures++; $display("FAIL sat_err got=%b exp=1", ifb.stall_err); end
    #2 rst_n = 0;
    #1;
    model_reset();
    checks++; if (ifb.stall_cnt !== 4'h0 || ifa.stall_cnt !== 16'h0 || ifa.stall_err !== 1'b0 || ifb.stall_err !== 1'b0) begin
      failures++; $display("FAIL async_rst_stats sc4=%h sc16=%h err=%b exp=0/0/0", ifb.stall_cnt, ifa.stall_cnt, ifa.stall_err); end
    checks++; if (ifa.if_id_valid !== 1'b0 || ifa.if_id_instr !== NOP || ifa.if_id_pc !== 32'h0) begin
      failures++; $display("FAIL async_rst_reg v=%b ins=%h pc=%h", ifa.if_id_valid, ifa.if_id_instr, ifa.if_id_pc); end
    @(negedge clk); rst_n = 1;
    drive(0, 0, 32'h80, 32'h9);
    edge_step();
    checks++; if (ifa.if_id_pc !== 32'h80 || ifa.if_id_valid !== 1'b1 || ifa.stall_cnt !== 16'd0) begin
      failures++; $display("FAIL post_rst_load pc=%h v=%b sc=%0d exp=80/1/0", ifa.if_id_pc, ifa.if_id_valid, ifa.stall_cnt); end
  endtask

  initial begin
    rst_n = 0;
    stall_in = 0; branch_taken = 0; if_pc = 0; if_instr = 0;
    @(negedge clk);
    test_reset();
    test_fetch();
    test_stall();
    test_flush();
    test_both();
    test_watchdog();
    test_random();
    test_saturate_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
